mem_responder: RTL and testbench

- Responder side of the controller's memory interface: services mem_read / mem_write requests against a word-organised data RAM.
- Configurable wait states; completion signalled with a one-cycle ready pulse.
- Sits between the multicycle controller/datapath and storage. Shared by the instruction-fetch and data/stack paths; address muxing happens upstream.

---
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: responder side of the controller memory interface.
//
// Services mem_read / mem_write requests against a word-organised data RAM
// of DEPTH 32-bit words.  A request is accepted on the rising edge seen in
// IDLE.  After LATENCY wait cycles a one-cycle ready pulse signals
// completion.  The FSM then parks in DRAIN until the requester drops both
// request lines, so a request held across completion is serviced only once.
//
// Handshake: mem_read/mem_write are held high by the requester until ready
// or addr_err pulses.  ready and addr_err are mutually exclusive one-cycle
// pulses.  rdata is valid while ready=1 and holds until the next read
// completes.  busy is high from the cycle after acceptance until the FSM is
// back in IDLE.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject accesses whose
// addr[1:0] != 0.  Without it the low address bits are ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mem_read   read request
//   mem_write  write request
//   addr       byte address; word index = addr[log2(DEPTH)+1:2]
//   wdata      write data, sampled at acceptance
//   rdata      read data
//   ready      one-cycle completion pulse
//   busy       transaction in progress
//   addr_err   one-cycle pulse for a rejected request (instead of ready)
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ready,
    output logic          busy,
    output logic          addr_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // WAIT spends LATENCY cycles, counting LATENCY-1 down to 0.
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          req_bad;
    logic [IW-1:0] in_idx;
    logic [AW-1:0] addr_hi;

    // Completion of a good access on the edge entering DONE.
    logic          comp;
    logic          comp_wr;
    logic [IW-1:0] comp_idx;
    logic [31:0]   comp_wdata;
    logic          mem_we;

    assign req     = mem_read | mem_write;
    assign in_idx  = addr[IW+1:2];
    assign addr_hi = addr >> (IW + 2);

`ifdef MEM_ALIGN_CHECK_EN
    assign req_bad = (mem_read & mem_write) | (addr_hi != '0) | (addr[1:0] != 2'b00);
`else
    assign req_bad = (mem_read & mem_write) | (addr_hi != '0);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        comp       = 1'b0;
        comp_wr    = is_wr_q;
        comp_idx   = idx_q;
        comp_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = in_idx;
                    wdata_d = wdata;
                    is_wr_d = mem_write;
                    if (req_bad) begin
                        // Rejected: straight to the error cycle, RAM untouched.
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (LATENCY == 0) begin
                        // Nothing latched yet, so complete from the live inputs.
                        state_d    = DONE;
                        comp       = 1'b1;
                        comp_wr    = mem_write;
                        comp_idx   = in_idx;
                        comp_wdata = wdata;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    comp    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_we = comp & comp_wr;
        if (comp) begin
            ready_d = 1'b1;
            if (!comp_wr) begin
                rdata_d = mem[comp_idx];
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset; a write is suppressed if reset is high at its edge.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[comp_idx] <= comp_wdata;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder.
// Instance a uses LATENCY=2, instance b uses LATENCY=0 (both DEPTH=256).
// The driver pushes the expected response (error flag, data, due cycle) into
// a per-instance queue; a negedge monitor pops and compares on every
// ready/addr_err pulse, so an unexpected extra pulse is also caught.
module tb_mem_responder;

  logic clk;
  logic reset;

  logic        a_rd, a_wr, a_ready, a_busy, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_rd, b_wr, b_ready, b_busy, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // entry: [49]=err, [48]=check data, [47:16]=data, [15:0]=due cycle
  logic [49:0] exp_qa[$];
  logic [49:0] exp_qb[$];

  mem_responder #(.DEPTH(256), .LATENCY(2), .AW(32)) dut_a (
    .clk(clk), .reset(reset), .mem_read(a_rd), .mem_write(a_wr),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready),
    .busy(a_busy), .addr_err(a_err)
  );

  mem_responder #(.DEPTH(256), .LATENCY(0), .AW(32)) dut_b (
    .clk(clk), .reset(reset), .mem_read(b_rd), .mem_write(b_wr),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready),
    .busy(b_busy), .addr_err(b_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    logic [49:0] e;
    if (a_ready || a_err) begin
      chk("a_ready_and_err", {31'd0, a_ready & a_err}, 32'd0);
      if (exp_qa.size() == 0) begin
        chk("a_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_qa.pop_front();
        chk("a_err_kind", {31'd0, a_err}, {31'd0, e[49]});
        chk("a_latency", {16'd0, cyc[15:0]}, {16'd0, e[15:0]});
        if (e[48]) chk("a_rdata", a_rdata, e[47:16]);
      end
    end
  end

  always @(negedge clk) begin
    logic [49:0] e;
    if (b_ready || b_err) begin
      chk("b_ready_and_err", {31'd0, b_ready & b_err}, 32'd0);
      if (exp_qb.size() == 0) begin
        chk("b_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_qb.pop_front();
        chk("b_err_kind", {31'd0, b_err}, {31'd0, e[49]});
        chk("b_latency", {16'd0, cyc[15:0]}, {16'd0, e[15:0]});
        if (e[48]) chk("b_rdata", b_rdata, e[47:16]);
      end
    end
  end

  // driver: called just after a rising edge; holds the request until the
  // response plus 'extra' cycles, then drops it and waits for busy to clear.
  task automatic req(input int sel, input bit rd, input bit wr,
                     input logic [31:0] ad, input logic [31:0] wd,
                     input int extra, input bit exp_err, input logic [31:0] exp_d);
    logic [49:0] e;
    int lat;
    bit got;
    lat = (sel == 0) ? 2 : 0;
    e[49] = exp_err;
    e[48] = rd & ~wr & ~exp_err;
    e[47:16] = exp_d;
    e[15:0] = 16'(cyc + 1 + (exp_err ? 0 : lat));
    if (sel == 0) begin
      exp_qa.push_back(e);
      a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
    end else begin
      exp_qb.push_back(e);
      b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = wd;
    end
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (n == 0) chk("busy_after_accept", {31'd0, (sel == 0) ? a_busy : b_busy}, 32'd1);
      if ((sel == 0) ? (a_ready | a_err) : (b_ready | b_err)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("response_timeout", 32'd0, 32'd1);
    repeat (extra) begin
      @(posedge clk); #1;
    end
    if (sel == 0) begin a_rd = 1'b0; a_wr = 1'b0; end
    else begin b_rd = 1'b0; b_wr = 1'b0; end
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (!((sel == 0) ? a_busy : b_busy)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("busy_clear_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
    b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_rdata", a_rdata, 32'd0);
    chk("reset_a_ready", {31'd0, a_ready}, 32'd0);
    chk("reset_a_busy", {31'd0, a_busy}, 32'd0);
    chk("reset_a_err", {31'd0, a_err}, 32'd0);
    chk("reset_b_rdata", b_rdata, 32'd0);
    chk("reset_b_busy", {31'd0, b_busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // LATENCY=2: write, held three extra cycles (single write only)
    req(0, 0, 1, 32'h10, 32'hDEADBEEF, 3, 0, 32'h0);
    // read-back, rdata must hold after ready drops
    req(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF);
    chk("a_rdata_hold", a_rdata, 32'hDEADBEEF);

    // errors
    req(0, 0, 1, 32'h8, 32'hA5A5A5A5, 0, 0, 32'h0);
    req(0, 1, 1, 32'h8, 32'h12345678, 1, 1, 32'h0);
    chk("a_rdata_after_err", a_rdata, 32'hDEADBEEF);
    req(0, 1, 0, 32'h8, 32'h0, 0, 0, 32'hA5A5A5A5);
    req(0, 1, 0, 32'h400, 32'h0, 0, 1, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    req(0, 1, 0, 32'h11, 32'h0, 0, 1, 32'h0);
`else
    req(0, 1, 0, 32'h11, 32'h0, 0, 0, 32'hDEADBEEF);
`endif

    // top word of the RAM
    req(0, 0, 1, 32'h3FC, 32'hCAFEF00D, 0, 0, 32'h0);
    req(0, 1, 0, 32'h3FC, 32'h0, 0, 0, 32'hCAFEF00D);

    // reset during WAIT of a write: old contents survive
    req(0, 0, 1, 32'h20, 32'h11111111, 0, 0, 32'h0);
    a_wr = 1'b1; a_addr = 32'h20; a_wdata = 32'h55;
    @(posedge clk); #1;   // accepted, WAIT cnt=1
    @(posedge clk); #1;   // WAIT cnt=0
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, a_busy}, 32'd0);
    chk("midrst_ready", {31'd0, a_ready}, 32'd0);
    chk("midrst_rdata", a_rdata, 32'd0);
    chk("midrst_err", {31'd0, a_err}, 32'd0);
    a_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    req(0, 1, 0, 32'h20, 32'h0, 0, 0, 32'h11111111);

    // LATENCY=0 instance
    req(1, 0, 1, 32'h4, 32'h00000001, 3, 0, 32'h0);
    req(1, 1, 0, 32'h4, 32'h0, 3, 0, 32'h00000001);
    chk("b_rdata_hold", b_rdata, 32'h00000001);

    repeat (5) @(posedge clk);
    #1;
    chk("a_queue_empty", exp_qa.size(), 32'd0);
    chk("b_queue_empty", exp_qb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
